fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch front end of the RVX10 five-stage pipeline; feeds the decode stage (regfile read ports, immediate extender).
- Owns the fetch PC and issues in-order word requests to instruction memory over a valid/ready port.
- Buffers returned instructions with their PCs in a DEPTH-entry queue and presents the head to decode.
- Handles decode back-pressure and branch/jump redirects, including discarding stale in-flight responses.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2; also caps buffered + in-flight fetches.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  instruction memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address; equals the fetch PC.
- imem_rsp_valid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  returned instruction word.
- redirect  in  1  taken branch/jump from execute; highest priority.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and treated as 0.
- stall_d  in  1  decode cannot accept an instruction this cycle.
- instr_valid_d  out  1  head entry valid.
- instr_d  out  32  head instruction; NOP 32'h0000_0013 when empty.
- pc_d  out  32  head PC; 0 when empty.
- pcplus4_d  out  32  pc_d + 4, modulo 2^32; 0 when empty.

Behaviour:
- Reset (synchronous): fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, inflight=0, drop_cnt=0.
  - Outputs during and after reset: imem_req_valid=0 in the reset cycle, instr_valid_d=0, instr_d=NOP, pc_d=0, pcplus4_d=0.
  - A reset mid-operation abandons all outstanding responses; the bench must not return old responses after reset.
- Credit rule: imem_req_valid = !reset && !redirect && (count + inflight < DEPTH).
  - Every accepted response therefore has a free queue slot; the push never overflows.
- Request accept (valid && ready): fetch_pc += 4 (wraps at 2^32); inflight += 1.
  - imem_req_addr follows fetch_pc combinationally.
  - The memory samples only on valid&&ready, so dropping valid on redirect is legal.
- Response: inflight -= 1.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise push {rsp_pc, imem_rsp_data} and set rsp_pc += 4.
  - A pushed entry is visible at the head no earlier than the next cycle (no bypass).
- Pop: when instr_valid_d && !stall_d, the head is consumed at the clock edge.
  - Simultaneous push and pop is legal at any occupancy, including full.
- Redirect (cycle N) has priority over pop, push, and request.
  - Queue is cleared and fetch_pc = rsp_pc = {redirect_pc[31:2],2'b00}.
  - drop_cnt = inflight − (imem_rsp_valid ? 1 : 0). A response arriving in cycle N is itself discarded.
  - inflight is updated normally.
  - No request is issued in cycle N; the first request to redirect_pc is presented in cycle N+1.
- Redirect with zero responses outstanding: drop_cnt=0. Back-to-back redirects: the last one wins.
- Latency: with an always-ready, 1-cycle memory, redirect at N gives request at N+1, response at N+2, and instr_valid_d at N+3 with pc_d=target.
- Steady state with no stall: one instruction per cycle once DEPTH ≥ memory latency + 1.
- A response with inflight==0 is illegal. The RTL ignores it, and the bench asserts that it never happens.

Decomposition:
- Add to the shared package rvx10_pkg:
  - constant NOP_INSTR=32'h0000_0013;
  - constant XLEN=32;
  - packed struct fetch_entry_t {pc[31:0], instr[31:0]}.
- One sub-module: fetch_fifo.
  - Synchronous, parameterised DEPTH, element type fetch_entry_t.
  - Signals: push, pop, flush (flush has priority), count output, empty, full.
  - Pointer wrap via an extra MSB.
- fetch_queue holds the PC, inflight, and drop_cnt logic.

Test Plan:
- Reset, then an always-ready 1-cycle memory returning addr^32'hA5A5_0000 with no stall → instr_valid_d first high 3 cycles after reset deasserts. pc_d=0,4,8,… one per cycle; instr_d matches.
- Hold stall_d=1 for 10 cycles → queue fills to DEPTH=4 with pc 0..0xC, and imem_req_valid drops once count+inflight=4. Release stall → 0,4,8,C,10 in order with no gaps or duplicates.
- Memory latency 3 cycles with 2 requests outstanding; redirect to 0x100 → both stale responses discarded. Next instr_valid_d shows pc_d=0x100, pcplus4_d=0x104.
- Redirect in the same cycle as a response and a pop at full → queue empty next cycle, response dropped, and the first request in the following cycle has addr=0x200.
- Redirect to 0xFFFF_FFFC → pc_d=0xFFFF_FFFC then 0x0000_0000; pcplus4_d wraps to 0.
- Assert reset while 2 fetches are in flight with the queue half full → next cycle instr_valid_d=0, instr_d=NOP, and imem_req_addr=RESET_PC.

Source files
------------

// File: rtl/rvx10_pkg.sv
// rvx10_pkg: definitions shared across the RVX10 pipeline front end.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical NOP (addi x0,x0,0) shown to decode when nothing is valid
//   fetch_entry_t : one buffered fetch result, the instruction plus the PC it came from
//   word_align()  : clears address bits [1:0]
package rvx10_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t.
//   clk, reset : clock and synchronous active-high reset (empties the FIFO)
//   push/push_data : enqueue an entry (accepted when not full, or when popping)
//   pop        : dequeue the head (ignored when empty)
//   flush      : empties the FIFO; wins over push and pop
//   head       : current head entry, read combinationally from the array
//   count/empty/full : occupancy status
// Pointers carry one extra MSB so full and empty are distinguishable
// without a separate occupancy register.
module fetch_fifo
  import rvx10_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         do_push;
  logic         do_pop;

  assign count = wr_ptr_reg - rd_ptr_reg;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr_reg[AW-1:0]];

  // A push into a full FIFO is fine when the head leaves at the same edge:
  // the slot written is the one being vacated.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end feeding the decode stage.
//   clk, reset        : clock, synchronous active-high reset
//   imem_req_*        : in-order word fetch requests (valid/ready, address = fetch PC)
//   imem_rsp_*        : in-order responses, at least one cycle after acceptance
//   redirect/redirect_pc : taken branch/jump target from execute (highest priority)
//   stall_d           : decode cannot take the head this cycle
//   instr_valid_d, instr_d, pc_d, pcplus4_d : head of the fetch queue (NOP/0 when empty)
// Requests are credit-limited so queued + in-flight never exceeds DEPTH; every
// response therefore has a slot. After a redirect, responses to requests
// issued before it are counted off by drop_cnt and discarded.
module fetch_queue
  import rvx10_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  output logic            instr_valid_d,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0]   inflight_reg, inflight_next;
  logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;

  logic [CW-1:0]   count;
  logic            empty;
  logic            full;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            req_fire;
  logic            rsp_ok;
  logic            push;
  logic            pop;
  logic            head_valid;
  logic [CW:0]     outstanding;

  // A response with nothing in flight is illegal and simply ignored.
  assign rsp_ok      = imem_rsp_valid && (inflight_reg != '0);
  assign outstanding = (CW+1)'(count) + (CW+1)'(inflight_reg);

  assign imem_req_valid = !reset && !redirect && (outstanding < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign head_valid = !empty && !reset;
  assign pop        = head_valid && !stall_d && !redirect;
  assign push       = rsp_ok && (drop_cnt_reg == '0) && !redirect && (!full || pop);
  assign push_entry = '{pc: rsp_pc_reg, instr: imem_rsp_data};

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    rsp_pc_next   = rsp_pc_reg;
    drop_cnt_next = drop_cnt_reg;
    inflight_next = inflight_reg + CW'(req_fire) - CW'(rsp_ok);
    if (redirect) begin
      fetch_pc_next = word_align(redirect_pc);
      rsp_pc_next   = word_align(redirect_pc);
      // Everything still outstanding after this edge belongs to the old path.
      drop_cnt_next = inflight_reg - CW'(rsp_ok);
    end else begin
      if (req_fire) fetch_pc_next = fetch_pc_reg + 32'd4;
      if (rsp_ok) begin
        if (drop_cnt_reg != '0) drop_cnt_next = drop_cnt_reg - 1'b1;
        else                    rsp_pc_next   = rsp_pc_reg + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      rsp_pc_reg   <= rsp_pc_next;
      inflight_reg <= inflight_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign instr_valid_d = head_valid;
  assign instr_d       = head_valid ? head.instr : NOP_INSTR;
  assign pc_d          = head_valid ? head.pc : '0;
  assign pcplus4_d     = head_valid ? head.pc + 32'd4 : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized bench for fetch_queue against a transaction-level model.
// The memory model keeps pending requests tagged with a path epoch; a redirect
// or reset starts a new epoch, and only same-epoch responses reach decode.
module tb_fetch_queue;
  import rvx10_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic        instr_valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall_d),
    .instr_valid_d  (instr_valid_d),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pcplus4_d      (pcplus4_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pend[$];     // accepted, not yet answered
  logic [31:0] mq_pc[$];    // PCs decode should see, in order
  logic [31:0] m_fetch_pc;
  int          epoch;
  int          cyc;
  int          last_due;
  int          n_cmp;
  int          n_err;

  logic        g_reset, g_redirect, g_stall;
  logic [31:0] g_target;
  int          g_ready_pct, g_lat_lo, g_lat_hi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic  rsp;
    logic  exp_rv;
    req_t  r;
    int    lat;
    int    due;
    @(posedge clk);
    #1;
    reset          = g_reset;
    redirect       = g_redirect;
    redirect_pc    = g_target;
    stall_d        = g_stall;
    imem_req_ready = ($urandom_range(99) < g_ready_pct);
    rsp            = !g_reset && (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? (pend[0].addr ^ KEY) : $urandom;
    #1;
    exp_rv = !g_reset && !g_redirect && ((mq_pc.size() + pend.size()) < DEPTH);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (!g_reset) chk("req_addr", imem_req_addr, m_fetch_pc);
    if (!g_reset && mq_pc.size() > 0) begin
      chk("instr_valid", {31'b0, instr_valid_d}, 32'd1);
      chk("pc_d", pc_d, mq_pc[0]);
      chk("instr_d", instr_d, mq_pc[0] ^ KEY);
      chk("pcplus4_d", pcplus4_d, mq_pc[0] + 32'd4);
      if (!g_stall && !g_redirect)
        $display("cyc %0d pop pc=%h instr=%h", cyc, pc_d, instr_d);
    end else begin
      chk("instr_valid", {31'b0, instr_valid_d}, 32'd0);
      chk("instr_nop", instr_d, NOP_INSTR);
      chk("pc_empty", pc_d, 32'd0);
      chk("pcplus4_empty", pcplus4_d, 32'd0);
    end
    // Advance the model across the coming clock edge.
    if (g_reset) begin
      pend.delete();
      mq_pc.delete();
      m_fetch_pc = RESET_PC;
      epoch++;
      last_due = 0;
    end else begin
      if (rsp) r = pend.pop_front();
      if (g_redirect) begin
        mq_pc.delete();
        m_fetch_pc = g_target & ~32'h3;
        epoch++;
      end else begin
        if (mq_pc.size() > 0 && !g_stall) void'(mq_pc.pop_front());
        if (rsp && r.epoch == epoch) mq_pc.push_back(r.addr);
        if (exp_rv && imem_req_ready) m_fetch_pc = m_fetch_pc + 32'd4;
      end
      // Memory answers whatever handshake the design actually makes.
      if (imem_req_valid && imem_req_ready) begin
        lat = $urandom_range(g_lat_hi, g_lat_lo);
        due = cyc + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        pend.push_back('{imem_req_addr, epoch, due});
      end
    end
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_valid;
    int last_rst;
    n_cmp = 0; n_err = 0; cyc = 0; epoch = 0; last_due = 0;
    m_fetch_pc = RESET_PC;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; stall_d = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    g_reset = 1'b1; g_redirect = 1'b0; g_stall = 1'b0; g_target = '0;
    g_ready_pct = 100; g_lat_lo = 1; g_lat_hi = 1;

    // Reset then streaming with a 1-cycle, always-ready memory.
    repeat (2) step();
    last_rst = cyc - 1;
    g_reset = 1'b0;
    first_valid = -1;
    repeat (12) begin
      step();
      if (first_valid < 0 && instr_valid_d) first_valid = cyc - 1;
    end
    chk("first_valid_latency", first_valid - last_rst, 32'd3);

    // Back-pressure: queue fills, credits run out.
    g_stall = 1'b1;
    repeat (10) step();
    chk("stall_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_head_valid", {31'b0, instr_valid_d}, 32'd1);
    g_stall = 1'b0;
    repeat (10) step();

    // 3-cycle memory, redirect with requests outstanding.
    g_lat_lo = 3; g_lat_hi = 3;
    repeat (6) step();
    g_redirect = 1'b1; g_target = 32'h0000_0100;
    step();
    g_redirect = 1'b0;
    repeat (10) step();

    // Redirect while responses land and decode pops; low target bits ignored.
    g_lat_lo = 2; g_lat_hi = 2; g_stall = 1'b1;
    repeat (3) step();
    g_stall = 1'b0; g_redirect = 1'b1; g_target = 32'h0000_0203;
    step();
    g_redirect = 1'b0;
    step();
    chk("redir_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("redir_first_req_addr", imem_req_addr, 32'h0000_0200);
    repeat (8) step();

    // Address wrap at the top of the space.
    g_lat_lo = 1; g_lat_hi = 1;
    g_redirect = 1'b1; g_target = 32'hFFFF_FFFC;
    step();
    g_redirect = 1'b0;
    repeat (8) step();

    // Reset mid-operation with fetches in flight.
    g_lat_lo = 3; g_lat_hi = 3; g_stall = 1'b1;
    repeat (4) step();
    g_reset = 1'b1;
    step();
    g_reset = 1'b0;
    step();
    chk("post_reset_valid", {31'b0, instr_valid_d}, 32'd0);
    chk("post_reset_nop", instr_d, NOP_INSTR);
    chk("post_reset_addr", imem_req_addr, RESET_PC);
    g_stall = 1'b0;
    repeat (8) step();

    // Random traffic.
    g_ready_pct = 70; g_lat_lo = 1; g_lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      g_stall    = ($urandom_range(99) < 30);
      g_redirect = ($urandom_range(99) < 4);
      g_target   = $urandom;
      g_reset    = ($urandom_range(999) < 3);
      step();
    end
    g_reset = 1'b0; g_redirect = 1'b0; g_stall = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
